core_sequencer_nested: RTL and testbench

CORE_SEQUENCER_NESTED -- requirements
Module: core_sequencer_nested

---
 rtl/core_sequencer_nested.sv | 203 ++++++++++++++++++++
 tb/tb_core_sequencer_nested.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_nested.sv
// rtl/core_sequencer_nested.sv - program sequencer with prioritised, nested interrupt handling
// Drains the pipeline before servicing an interrupt and keeps a small cause stack so handlers can nest.
module core_sequencer_nested #(
    parameter int  NUM_IRQ       = 4,
    parameter int  NEST_DEPTH    = 2,
    parameter int  DRAIN_TIMEOUT = 16,
    localparam int CW            = (NUM_IRQ > 2) ? $clog2(NUM_IRQ) : 1,
    localparam int LW            = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               master_reset,
    input  logic               start_program,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               ret_from_irq,
    input  logic               reset_trigger,
    input  logic               program_done,
    input  logic               fetch_ready,
    input  logic               all_ready,
    output logic [2:0]         state_out,
    output logic               begin_execution,
    output logic               flush_partial,
    output logic               flush_full,
    output logic               global_reset,
    output logic               run_irq_handler,
    output logic               done_flag,
    output logic               csr_save,
    output logic               csr_restore,
    output logic [CW-1:0]      irq_cause,
    output logic [LW-1:0]      nest_level,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PROGRAM    = 3'd1,
        S_PARTIAL    = 3'd2,
        S_IRQ_HANDLE = 3'd3,
        S_FULL_FLUSH = 3'd4,
        S_DONE       = 3'd5,
        S_RESTORE    = 3'd6
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cause, cause_d;
    logic [LW-1:0] level, level_d;
    logic [7:0]    cnt, cnt_d;
    logic          terr, terr_d;
    logic          push, clear_stack;
    logic [CW-1:0] stack [NEST_DEPTH];
    logic [CW-1:0] low_idx, pop_val;
    logic [LW-1:0] stack_idx;
    logic          any_irq, drain_expired, preempt;

    // Lowest set index wins: scan from the top so the last hit is the highest priority.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) low_idx = CW'(i);
        end
    end

    // Push at level L stores into slot L-1; after the RESTORE decrement, slot L-1 holds the outer cause.
    assign stack_idx = level - 1'b1;

    always_comb begin
        pop_val = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (stack_idx == LW'(i)) pop_val = stack[i];
        end
    end

    assign any_irq       = |irq_req;
    assign drain_expired = (cnt == 8'(DRAIN_TIMEOUT - 1));
    assign preempt       = any_irq && (low_idx < cause) && (level < LW'(NEST_DEPTH));

    always_comb begin
        state_d     = state;
        cause_d     = cause;
        level_d     = level;
        terr_d      = terr;
        push        = 1'b0;
        clear_stack = 1'b0;
        if (master_reset) begin
            state_d     = S_IDLE;
            cause_d     = '0;
            level_d     = '0;
            terr_d      = 1'b0;
            clear_stack = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_program) begin
                        state_d = S_PROGRAM;
                        terr_d  = 1'b0;
                    end
                end
                S_PROGRAM: begin
                    if (reset_trigger) begin
                        state_d = S_FULL_FLUSH;
                    end else if (any_irq) begin
                        state_d = S_PARTIAL;
                        cause_d = low_idx;
                        level_d = LW'(1);
                    end else if (program_done) begin
                        state_d = S_DONE;
                    end
                end
                S_PARTIAL: begin
                    if (fetch_ready) begin
                        state_d = S_IRQ_HANDLE;
                    end else if (drain_expired) begin
                        state_d     = S_FULL_FLUSH;
                        terr_d      = 1'b1;
                        level_d     = '0;
                        clear_stack = 1'b1;
                    end
                end
                S_IRQ_HANDLE: begin
                    if (ret_from_irq) begin
                        state_d = S_RESTORE;
                        level_d = level - 1'b1;
                    end else if (preempt) begin
                        state_d = S_PARTIAL;
                        push    = 1'b1;
                        cause_d = low_idx;
                        level_d = level + 1'b1;
                    end
                end
                S_FULL_FLUSH: begin
                    if (all_ready || drain_expired) begin
                        state_d     = S_IDLE;
                        cause_d     = '0;
                        level_d     = '0;
                        clear_stack = 1'b1;
                        if (!all_ready) terr_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_RESTORE: begin
                    if (level == '0) begin
                        state_d = S_PROGRAM;
                    end else begin
                        state_d = S_IRQ_HANDLE;
                        cause_d = pop_val;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        // Counter restarts on every state change and only runs while draining.
        if (master_reset || (state_d != state)) begin
            cnt_d = '0;
        end else if ((state == S_PARTIAL) || (state == S_FULL_FLUSH)) begin
            cnt_d = cnt + 8'd1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cause <= '0;
            level <= '0;
            cnt   <= '0;
            terr  <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
        end else begin
            state <= state_d;
            cause <= cause_d;
            level <= level_d;
            cnt   <= cnt_d;
            terr  <= terr_d;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (clear_stack) begin
                    stack[i] <= '0;
                end else if (push && (stack_idx == LW'(i))) begin
                    stack[i] <= cause;
                end
            end
        end
    end

    assign state_out       = state;
    assign begin_execution = (state == S_PROGRAM);
    assign flush_partial   = (state == S_PARTIAL);
    assign flush_full      = (state == S_FULL_FLUSH);
    assign global_reset    = (state == S_FULL_FLUSH);
    assign run_irq_handler = (state == S_IRQ_HANDLE);
    assign done_flag       = (state == S_DONE);
    // The counter is zero only on the first cycle of a PARTIAL visit.
    assign csr_save        = (state == S_PARTIAL) && (cnt == 8'd0);
    assign csr_restore     = (state == S_RESTORE);
    assign irq_cause       = cause;
    assign nest_level      = level;
    assign timeout_err     = terr;

endmodule

// File: tb/tb_core_sequencer_nested.sv
// tb/tb_core_sequencer_nested.sv - directed self-checking bench for core_sequencer_nested
module tb_core_sequencer_nested;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       master_reset, start_program, ret_from_irq, reset_trigger;
    logic       program_done, fetch_ready, all_ready;
    logic [3:0] irq_req;
    logic [2:0] state_out;
    logic       begin_execution, flush_partial, flush_full, global_reset;
    logic       run_irq_handler, done_flag, csr_save, csr_restore, timeout_err;
    logic [1:0] irq_cause;
    logic [1:0] nest_level;
    int         checks = 0;
    int         failures = 0;

    core_sequencer_nested #(.NUM_IRQ(4), .NEST_DEPTH(2), .DRAIN_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .master_reset(master_reset), .start_program(start_program),
        .irq_req(irq_req), .ret_from_irq(ret_from_irq), .reset_trigger(reset_trigger),
        .program_done(program_done), .fetch_ready(fetch_ready), .all_ready(all_ready),
        .state_out(state_out), .begin_execution(begin_execution), .flush_partial(flush_partial),
        .flush_full(flush_full), .global_reset(global_reset), .run_irq_handler(run_irq_handler),
        .done_flag(done_flag), .csr_save(csr_save), .csr_restore(csr_restore),
        .irq_cause(irq_cause), .nest_level(nest_level), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        master_reset = 0; start_program = 0; ret_from_irq = 0; reset_trigger = 0;
        program_done = 0; fetch_ready = 0; all_ready = 0; irq_req = 4'b0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        checks++; if ({nest_level, irq_cause, timeout_err, csr_save} !== 6'd0) begin failures++; $display("FAIL reset_regs got=%b exp=0", {nest_level, irq_cause, timeout_err, csr_save}); end
        #14 rst_n = 1;
        tick(1);
        checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL reset_release state got=%0d exp=0", state_out); end
    endtask

    task automatic test_basic();
        start_program = 1; tick(1); start_program = 0;
        checks++; if (state_out !== 3'd1 || begin_execution !== 1'b1) begin failures++; $display("FAIL basic_program state=%0d be=%b exp=1/1", state_out, begin_execution); end
        tick(10);
        checks++; if (state_out !== 3'd1) begin failures++; $display("FAIL basic_hold state got=%0d exp=1", state_out); end
        program_done = 1; tick(1); program_done = 0;
        checks++; if (state_out !== 3'd5 || done_flag !== 1'b1) begin failures++; $display("FAIL basic_done state=%0d done=%b exp=5/1", state_out, done_flag); end
        start_program = 1; reset_trigger = 1; irq_req = 4'b0001; tick(2);
        checks++; if (state_out !== 3'd5) begin failures++; $display("FAIL done_ignores state got=%0d exp=5", state_out); end
        clear_inputs(); master_reset = 1; tick(1); master_reset = 0;
        checks++; if (state_out !== 3'd0 || done_flag !== 1'b0) begin failures++; $display("FAIL basic_master state=%0d done=%b exp=0/0", state_out, done_flag); end
    endtask

    task automatic test_nesting();
        start_program = 1; tick(1); start_program = 0;
        irq_req = 4'b0100; fetch_ready = 1; tick(1);
        checks++; if (state_out !== 3'd2 || csr_save !== 1'b1 || flush_partial !== 1'b1) begin failures++; $display("FAIL nest_partial1 state=%0d save=%b fp=%b exp=2/1/1", state_out, csr_save, flush_partial); end
        tick(1);
        checks++; if (state_out !== 3'd3 || csr_save !== 1'b0 || irq_cause !== 2'd2 || nest_level !== 2'd1) begin failures++; $display("FAIL nest_handle1 state=%0d save=%b cause=%0d lvl=%0d exp=3/0/2/1", state_out, csr_save, irq_cause, nest_level); end
        tick(1);
        checks++; if (state_out !== 3'd3 || irq_cause !== 2'd2) begin failures++; $display("FAIL nest_equal_prio state=%0d cause=%0d exp=3/2", state_out, irq_cause); end
        irq_req = 4'b0001; tick(1);
        checks++; if (state_out !== 3'd2 || csr_save !== 1'b1 || irq_cause !== 2'd0 || nest_level !== 2'd2) begin failures++; $display("FAIL nest_partial2 state=%0d save=%b cause=%0d lvl=%0d exp=2/1/0/2", state_out, csr_save, irq_cause, nest_level); end
        tick(1);
        checks++; if (state_out !== 3'd3 || irq_cause !== 2'd0 || nest_level !== 2'd2) begin failures++; $display("FAIL nest_handle2 state=%0d cause=%0d lvl=%0d exp=3/0/2", state_out, irq_cause, nest_level); end
        irq_req = 4'b0000; ret_from_irq = 1; tick(1); ret_from_irq = 0;
        checks++; if (state_out !== 3'd6 || csr_restore !== 1'b1 || nest_level !== 2'd1) begin failures++; $display("FAIL nest_restore1 state=%0d rest=%b lvl=%0d exp=6/1/1", state_out, csr_restore, nest_level); end
        tick(1);
        checks++; if (state_out !== 3'd3 || irq_cause !== 2'd2 || nest_level !== 2'd1) begin failures++; $display("FAIL nest_pop state=%0d cause=%0d lvl=%0d exp=3/2/1", state_out, irq_cause, nest_level); end
        ret_from_irq = 1; tick(1); ret_from_irq = 0;
        checks++; if (state_out !== 3'd6 || nest_level !== 2'd0) begin failures++; $display("FAIL nest_restore0 state=%0d lvl=%0d exp=6/0", state_out, nest_level); end
        tick(1);
        checks++; if (state_out !== 3'd1 || nest_level !== 2'd0) begin failures++; $display("FAIL nest_back_program state=%0d lvl=%0d exp=1/0", state_out, nest_level); end
        ret_from_irq = 1; tick(1); ret_from_irq = 0;
        checks++; if (state_out !== 3'd1 || nest_level !== 2'd0) begin failures++; $display("FAIL stray_ret state=%0d lvl=%0d exp=1/0", state_out, nest_level); end
        fetch_ready = 0;
    endtask

    task automatic test_depth_limit();
        irq_req = 4'b0100; fetch_ready = 1; tick(2);
        irq_req = 4'b0010; tick(2);
        checks++; if (state_out !== 3'd3 || irq_cause !== 2'd1 || nest_level !== 2'd2) begin failures++; $display("FAIL depth_setup state=%0d cause=%0d lvl=%0d exp=3/1/2", state_out, irq_cause, nest_level); end
        irq_req = 4'b0001; tick(3);
        checks++; if (state_out !== 3'd3 || irq_cause !== 2'd1 || nest_level !== 2'd2) begin failures++; $display("FAIL depth_no_preempt state=%0d cause=%0d lvl=%0d exp=3/1/2", state_out, irq_cause, nest_level); end
        ret_from_irq = 1; tick(1); ret_from_irq = 0;
        tick(1);
        checks++; if (state_out !== 3'd3 || irq_cause !== 2'd2 || nest_level !== 2'd1) begin failures++; $display("FAIL depth_pop state=%0d cause=%0d lvl=%0d exp=3/2/1", state_out, irq_cause, nest_level); end
        ret_from_irq = 1; tick(1); ret_from_irq = 0;
        checks++; if (state_out !== 3'd6 || nest_level !== 2'd0) begin failures++; $display("FAIL ret_beats_preempt state=%0d lvl=%0d exp=6/0", state_out, nest_level); end
        irq_req = 4'b0000; fetch_ready = 0; tick(1);
        checks++; if (state_out !== 3'd1) begin failures++; $display("FAIL depth_back_program state got=%0d exp=1", state_out); end
    endtask

    task automatic test_simultaneous();
        reset_trigger = 1; irq_req = 4'b0001; program_done = 1; tick(1);
        clear_inputs();
        checks++; if (state_out !== 3'd4 || flush_full !== 1'b1 || global_reset !== 1'b1) begin failures++; $display("FAIL simul_flush state=%0d ff=%b gr=%b exp=4/1/1", state_out, flush_full, global_reset); end
        all_ready = 1; tick(1); all_ready = 0;
        checks++; if (state_out !== 3'd0 || irq_cause !== 2'd0 || nest_level !== 2'd0) begin failures++; $display("FAIL flush_idle state=%0d cause=%0d lvl=%0d exp=0/0/0", state_out, irq_cause, nest_level); end
        irq_req = 4'b0001; tick(2); irq_req = 4'b0000;
        checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL idle_ignores_irq state got=%0d exp=0", state_out); end
    endtask

    task automatic test_timeout();
        start_program = 1; tick(1); start_program = 0;
        irq_req = 4'b0100; tick(16);
        checks++; if (state_out !== 3'd2 || timeout_err !== 1'b0) begin failures++; $display("FAIL partial_last_cycle state=%0d terr=%b exp=2/0", state_out, timeout_err); end
        irq_req = 4'b0000; tick(1);
        checks++; if (state_out !== 3'd4 || timeout_err !== 1'b1 || nest_level !== 2'd0) begin failures++; $display("FAIL partial_timeout state=%0d terr=%b lvl=%0d exp=4/1/0", state_out, timeout_err, nest_level); end
        all_ready = 1; tick(1); all_ready = 0;
        checks++; if (state_out !== 3'd0 || timeout_err !== 1'b1) begin failures++; $display("FAIL terr_sticky state=%0d terr=%b exp=0/1", state_out, timeout_err); end
        start_program = 1; tick(1); start_program = 0;
        checks++; if (state_out !== 3'd1 || timeout_err !== 1'b0) begin failures++; $display("FAIL terr_clear state=%0d terr=%b exp=1/0", state_out, timeout_err); end
        irq_req = 4'b0100; tick(16);
        fetch_ready = 1; tick(1);
        checks++; if (state_out !== 3'd3 || timeout_err !== 1'b0) begin failures++; $display("FAIL ready_wins state=%0d terr=%b exp=3/0", state_out, timeout_err); end
        clear_inputs(); ret_from_irq = 1; tick(1); ret_from_irq = 0; tick(1);
        checks++; if (state_out !== 3'd1) begin failures++; $display("FAIL ready_wins_return state got=%0d exp=1", state_out); end
        reset_trigger = 1; tick(1); reset_trigger = 0;
        tick(15);
        checks++; if (state_out !== 3'd4) begin failures++; $display("FAIL flush_last_cycle state got=%0d exp=4", state_out); end
        tick(1);
        checks++; if (state_out !== 3'd0 || timeout_err !== 1'b1) begin failures++; $display("FAIL flush_timeout state=%0d terr=%b exp=0/1", state_out, timeout_err); end
        start_program = 1; tick(1); start_program = 0;
    endtask

    task automatic test_master_reset();
        irq_req = 4'b0100; fetch_ready = 1; tick(2);
        master_reset = 1; ret_from_irq = 1; tick(1);
        clear_inputs();
        checks++; if (state_out !== 3'd0 || nest_level !== 2'd0 || irq_cause !== 2'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL master_reset state=%0d lvl=%0d cause=%0d terr=%b exp=0/0/0/0", state_out, nest_level, irq_cause, timeout_err); end
    endtask

    task automatic test_async_reset();
        start_program = 1; tick(1); start_program = 0;
        irq_req = 4'b0100; fetch_ready = 1; tick(2);
        irq_req = 4'b0001; tick(2);
        checks++; if (state_out !== 3'd3 || nest_level !== 2'd2) begin failures++; $display("FAIL async_setup state=%0d lvl=%0d exp=3/2", state_out, nest_level); end
        #2 rst_n = 0;
        #1;
        checks++; if (state_out !== 3'd0 || nest_level !== 2'd0 || irq_cause !== 2'd0) begin failures++; $display("FAIL async_regs state=%0d lvl=%0d cause=%0d exp=0/0/0", state_out, nest_level, irq_cause); end
        checks++; if ({begin_execution, flush_partial, flush_full, global_reset, run_irq_handler, done_flag, csr_save, csr_restore, timeout_err} !== 9'd0) begin failures++; $display("FAIL async_outputs got=%b exp=0", {begin_execution, flush_partial, flush_full, global_reset, run_irq_handler, done_flag, csr_save, csr_restore, timeout_err}); end
        clear_inputs(); start_program = 1;
        tick(1);
        checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL async_held state got=%0d exp=0", state_out); end
        #3 rst_n = 1;
        tick(1); start_program = 0;
        checks++; if (state_out !== 3'd1) begin failures++; $display("FAIL async_release state got=%0d exp=1", state_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_depth_limit();
        test_simultaneous();
        test_timeout();
        test_master_reset();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
